matrix_operand_loader: RTL and testbench

Upstream feeder for the 2x2 parallel matrix multiplier (`matrixArbParallel`). It accepts matrix elements one byte per transfer over a valid/ready stream and packs eight bytes into the two 32-bit operand words `a` and `b`. It then presents the pair to the multiplier with a valid/ready handshake and holds it stable until it is accepted. Framing is checked with a last-element marker; malformed frames are discarded and flagged.

---
 rtl/matrix_pkg.sv | 15 +
 rtl/matrix_pack_reg.sv | 36 +++
 rtl/matrix_operand_loader.sv | 137 +++++++++++++
 tb/tb_matrix_operand_loader.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix operand loader: element geometry,
// frame length and the loader FSM state encoding.
package matrix_pkg;

  localparam int ELEM_W    = 8;
  localparam int N_ELEM    = 4;
  localparam int FRAME_LEN = 2 * N_ELEM;

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    PRESENT = 2'd2
  } state_t;

endpackage

// File: rtl/matrix_pack_reg.sv
// Byte-lane write register: one element lane is written per cycle,
// lane 0 landing in the most significant element of the word.
module matrix_pack_reg #(
  parameter int ELEM_W = 8,
  parameter int N_ELEM = 4,
  localparam int LANE_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_i,
  input  logic                     we_i,
  input  logic [LANE_W-1:0]        lane_i,
  input  logic [ELEM_W-1:0]        data_i,
  output logic [ELEM_W*N_ELEM-1:0] word_o
);

  logic [ELEM_W*N_ELEM-1:0] word_q;

  // Clear wins over write; otherwise only the selected lane is updated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
    end else if (clr_i) begin
      word_q <= '0;
    end else begin
      for (int i = 0; i < N_ELEM; i++) begin
        if (we_i && (lane_i == LANE_W'(i))) begin
          word_q[(N_ELEM-1-i)*ELEM_W +: ELEM_W] <= data_i;
        end
      end
    end
  end

  assign word_o = word_q;

endmodule

// File: rtl/matrix_operand_loader.sv
// Packs an 8-element byte stream into operand words A and B and presents
// the pair to the 2x2 multiplier. Frames are checked against in_last;
// malformed frames are dropped and flagged in a sticky frame_err.
//
// Handshakes: a beat moves on a rising clk edge where valid && ready are
// both high. The producer holds valid and data stable until that edge; the
// consumer's ready never depends combinationally on valid. in_ready and
// out_valid are registered and never high together, so an element transfer
// and an operand handoff cannot coincide.
module matrix_operand_loader #(
  parameter int ELEM_W = matrix_pkg::ELEM_W,
  parameter int N_ELEM = matrix_pkg::N_ELEM,
  localparam int OP_W   = ELEM_W * N_ELEM,
  localparam int CNT_W  = $clog2(2 * N_ELEM),
  localparam int LANE_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ELEM_W-1:0] in_data,
  input  logic              in_last,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OP_W-1:0]   a_out,
  output logic [OP_W-1:0]   b_out,
  output logic              frame_err,
  output logic [CNT_W-1:0]  elem_cnt,
  output logic [1:0]        dbg_state
);

  import matrix_pkg::*;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               wr_a, wr_b, clr;
  logic               xfer, last_slot;

  assign xfer      = in_valid && in_ready_q;
  assign last_slot = (cnt_q == CNT_W'(2 * N_ELEM - 1));

  // Registered FSM state, element counter, error flag and handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= LOAD_A;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state logic: flush overrides everything, then framing check on each transfer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    wr_a    = 1'b0;
    wr_b    = 1'b0;
    clr     = 1'b0;
    if (flush) begin
      state_d = LOAD_A;
      cnt_d   = '0;
      err_d   = 1'b0;
      clr     = 1'b1;
    end else begin
      case (state_q)
        LOAD_A, LOAD_B: begin
          if (xfer) begin
            // The byte lands even on a bad transfer; partial lanes are simply overwritten later.
            wr_a = (state_q == LOAD_A);
            wr_b = (state_q == LOAD_B);
            if (in_last != last_slot) begin
              err_d   = 1'b1;
              cnt_d   = '0;
              state_d = LOAD_A;
            end else if (last_slot) begin
              cnt_d   = '0;
              state_d = PRESENT;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
              if (cnt_q == CNT_W'(N_ELEM - 1)) begin
                state_d = LOAD_B;
              end
            end
          end
        end
        PRESENT: begin
          if (out_valid_q && out_ready) begin
            state_d = LOAD_A;
          end
        end
        default: state_d = LOAD_A;
      endcase
    end
    // Handshake outputs are registered copies of what the next state implies.
    in_ready_d  = (state_d != PRESENT);
    out_valid_d = (state_d == PRESENT);
  end

  matrix_pack_reg #(.ELEM_W(ELEM_W), .N_ELEM(N_ELEM)) u_pack_a (
    .clk    (clk),
    .rst_n  (rst),
    .clr_i  (clr),
    .we_i   (wr_a),
    .lane_i (cnt_q[LANE_W-1:0]),
    .data_i (in_data),
    .word_o (a_out)
  );

  matrix_pack_reg #(.ELEM_W(ELEM_W), .N_ELEM(N_ELEM)) u_pack_b (
    .clk    (clk),
    .rst_n  (rst),
    .clr_i  (clr),
    .we_i   (wr_b),
    .lane_i (cnt_q[LANE_W-1:0]),
    .data_i (in_data),
    .word_o (b_out)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign frame_err = err_q;
  assign elem_cnt  = cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Bench for matrix_operand_loader: directed scenarios plus randomized frames,
// with a frame-level reference model feeding an expected-pair queue that a
// separate monitor drains on every handoff.
module tb_matrix_operand_loader;
  import matrix_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, out_valid, frame_err;
  logic [31:0] a_out, b_out;
  logic [2:0]  elem_cnt;
  logic [1:0]  dbg_state;

  matrix_operand_loader dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a_out     (a_out),
    .b_out     (b_out),
    .frame_err (frame_err),
    .elem_cnt  (elem_cnt),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  int          handoffs = 0;
  bit          rand_mode = 1'b0;
  bit          err_exp = 1'b0;
  logic [63:0] exp_q[$];
  logic [7:0]  frame_q[$];
  int          rise_q[$];
  logic        prev_valid = 1'b0;
  logic        prev_done = 1'b0;
  logic [63:0] prev_ab = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Frame-level model: a frame is good iff exactly 8 elements arrive with
  // in_last on the 8th; the pair is the 8 bytes concatenated in order.
  function automatic void model_accept(input logic [7:0] d, input bit last);
    logic [63:0] pair;
    frame_q.push_back(d);
    if (last || frame_q.size() == 8) begin
      if (last && frame_q.size() == 8) begin
        pair = '0;
        foreach (frame_q[i]) pair = {pair[55:0], frame_q[i]};
        exp_q.push_back(pair);
      end else begin
        err_exp = 1'b1;
      end
      frame_q.delete();
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send_elem(input logic [7:0] d, input bit last);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && guard < 100) begin
      tick();
      guard++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready stayed %0b, required 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    model_accept(d, last);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("elem_cnt", 64'(elem_cnt), 64'(frame_q.size()));
    chk("frame_err", 64'(frame_err), 64'(err_exp));
  endtask

  task automatic send_frame(input logic [7:0] first);
    for (int i = 0; i < 8; i++) send_elem(first + 8'(i), i == 7);
  endtask

  task automatic flush_cycle();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    frame_q.delete();
    err_exp = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_a", 64'(a_out), 64'd0);
    chk("flush_b", 64'(b_out), 64'd0);
    chk("flush_err", 64'(frame_err), 64'd0);
    chk("flush_cnt", 64'(elem_cnt), 64'd0);
    chk("flush_state", 64'(dbg_state), 64'(LOAD_A));
  endtask

  // ---------------- monitor (runs forked from main) ----------------
  task automatic monitor();
    logic [63:0] got;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_valid = 1'b0;
      end else begin
        got = {a_out, b_out};
        if (out_valid) begin
          if (prev_valid && !prev_done) chk("hold_stable", got, prev_ab);
          chk("in_ready_in_present", 64'(in_ready), 64'd0);
          if (!prev_valid) rise_q.push_back(cycle);
          if (out_ready && !flush) begin
            handoffs++;
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_pair: got %0h, required no pair", got);
            end else begin
              chk("pair", got, exp_q.pop_front());
            end
          end
        end
        prev_valid = out_valid;
        prev_done  = out_ready || flush;
        prev_ab    = got;
      end
    end
  endtask

  // ---------------- main sequence + report ----------------
  initial begin
    int h0;
    int bad;
    int len;
    fork
      monitor();
    join_none

    // Reset values
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_a", 64'(a_out), 64'd0);
    chk("rst_b", 64'(b_out), 64'd0);
    chk("rst_err", 64'(frame_err), 64'd0);
    chk("rst_cnt", 64'(elem_cnt), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(LOAD_A));
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("in_ready_after_reset", 64'(in_ready), 64'd1);

    // Basic frame, one-cycle presentation, 9-cycle period
    out_ready = 1'b1;
    send_frame(8'h01);
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_a", 64'(a_out), 64'h01020304);
    chk("t1_b", 64'(b_out), 64'h05060708);
    tick();
    chk("t1_valid_drop", 64'(out_valid), 64'd0);
    chk("t1_in_ready", 64'(in_ready), 64'd1);
    send_frame(8'h21);
    send_frame(8'h31);
    if (rise_q.size() >= 2)
      chk("period", 64'(rise_q[rise_q.size()-1] - rise_q[rise_q.size()-2]), 64'd9);
    else
      chk("period_rises", 64'(rise_q.size()), 64'd2);
    tick();

    // Backpressure: pair held for 5 cycles
    out_ready = 1'b0;
    send_frame(8'h01);
    h0 = handoffs;
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      tick();
    end
    chk("hold_a", 64'(a_out), 64'h01020304);
    out_ready = 1'b1;
    tick();
    chk("hold_handoff", 64'(handoffs - h0), 64'd1);
    chk("hold_released", 64'(out_valid), 64'd0);
    chk("hold_in_ready_back", 64'(in_ready), 64'd1);

    // in_last on the 3rd byte, then a good frame
    send_elem(8'h01, 1'b0);
    send_elem(8'h02, 1'b0);
    send_elem(8'h03, 1'b1);
    chk("early_last_valid", 64'(out_valid), 64'd0);
    chk("early_last_state", 64'(dbg_state), 64'(LOAD_A));
    tick();
    chk("early_last_valid2", 64'(out_valid), 64'd0);
    send_frame(8'h09);
    chk("recover_a", 64'(a_out), 64'h090A0B0C);
    chk("recover_b", 64'(b_out), 64'h0D0E0F10);
    chk("recover_err", 64'(frame_err), 64'd1);
    tick();

    // 8th byte without in_last, then flush
    flush_cycle();
    for (int i = 0; i < 8; i++) send_elem(8'(i + 1), 1'b0);
    chk("missing_last_valid", 64'(out_valid), 64'd0);
    tick();
    chk("missing_last_valid2", 64'(out_valid), 64'd0);
    chk("missing_last_err", 64'(frame_err), 64'd1);
    flush_cycle();

    // Asynchronous reset mid-frame
    for (int i = 0; i < 5; i++) send_elem(8'(8'h50 + i), 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("async_in_ready", 64'(in_ready), 64'd0);
    chk("async_a", 64'(a_out), 64'd0);
    chk("async_cnt", 64'(elem_cnt), 64'd0);
    chk("async_state", 64'(dbg_state), 64'(LOAD_A));
    frame_q.delete();
    exp_q.delete();
    err_exp = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    send_frame(8'h01);
    chk("post_reset_a", 64'(a_out), 64'h01020304);
    chk("post_reset_b", 64'(b_out), 64'h05060708);
    tick();

    // flush in PRESENT together with out_ready
    out_ready = 1'b0;
    send_frame(8'h41);
    chk("pre_flush_valid", 64'(out_valid), 64'd1);
    h0 = handoffs;
    out_ready = 1'b1;
    flush_cycle();
    tick();
    chk("flush_present_no_handoff", 64'(handoffs - h0), 64'd0);
    chk("flush_present_valid", 64'(out_valid), 64'd0);

    // Randomized frames with random gaps and backpressure
    rand_mode = 1'b1;
    for (int f = 0; f < 60; f++) begin
      bad = ($urandom_range(0, 4) == 0) ? 1 : 0;
      if (bad != 0) begin
        len = $urandom_range(1, 8);
        for (int i = 0; i < len; i++)
          send_elem(8'($urandom_range(0, 255)), (len < 8) && (i == len - 1));
      end else begin
        for (int i = 0; i < 8; i++)
          send_elem(8'($urandom_range(0, 255)), i == 7);
      end
      repeat ($urandom_range(0, 2)) tick();
    end
    rand_mode = 1'b0;
    out_ready = 1'b1;
    repeat (5) tick();
    chk("drain", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
